// File: rtl/param_rot_matrix.sv
// Lane rotator: rotates LANES x LANE_W-bit lanes left or right by a fixed or auto-stepped
// amount, with a one-deep registered output behind a valid/ready handshake.
module param_rot_matrix #(
    parameter int LANES  = 8,
    parameter int LANE_W = 8,
    parameter int SEL_W  = $clog2(LANES)
) (
    input  logic                      clk1,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*LANE_W-1:0]   din,
    input  logic [SEL_W-1:0]          select,
    input  logic [1:0]                mode,
    input  logic                      step_clr,
    output logic [LANES*LANE_W-1:0]   dout,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          step_cnt
);

    localparam int W  = LANES * LANE_W;
    // One extra bit holds sums up to 2*LANES-2 before the conditional subtract.
    localparam int AW = SEL_W + 1;
    localparam logic [AW-1:0] LANES_A = AW'(LANES);

    typedef enum logic [1:0] {
        MODE_FIX_L  = 2'b00,
        MODE_FIX_R  = 2'b01,
        MODE_AUTO_L = 2'b10,
        MODE_AUTO_R = 2'b11
    } mode_e;

    mode_e            mode_s;
    logic             auto_s;
    logic             right_s;
    logic             accept;

    logic [W-1:0]     dout_q, dout_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] step_q, step_d;

    logic [AW-1:0]    sel_ext;
    logic [AW-1:0]    sel_mod;
    logic [AW-1:0]    step_sum;
    logic [AW-1:0]    rot_amt;
    logic [AW-1:0]    rot_left_amt;
    logic [W-1:0]     rot_vec;

    assign mode_s  = mode_e'(mode);
    assign auto_s  = (mode_s == MODE_AUTO_L) || (mode_s == MODE_AUTO_R);
    assign right_s = (mode_s == MODE_FIX_R)  || (mode_s == MODE_AUTO_R);

    assign in_ready = enable && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // select < 2^SEL_W <= 2*LANES-1, so a single conditional subtract is an exact mod.
    assign sel_ext  = {1'b0, select};
    assign sel_mod  = (sel_ext >= LANES_A) ? (sel_ext - LANES_A) : sel_ext;
    assign step_sum = {1'b0, step_q} + sel_mod;

    assign rot_amt  = auto_s ? {1'b0, step_q} : sel_mod;
    // Right rotation by r is left rotation by (LANES-r) mod LANES; keeps indices below 2*LANES-1.
    assign rot_left_amt = (right_s && (rot_amt != '0)) ? (LANES_A - rot_amt) : rot_amt;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [W-1:0]      cand_flat;
        logic [LANE_W-1:0] lane_sel;

        // cand_flat slot k holds input lane (j+k) mod LANES, i.e. the lane chosen when r == k.
        for (genvar k = 0; k < LANES; k++) begin : g_cand
            assign cand_flat[k*LANE_W +: LANE_W] =
                din[(LANES-1-((j+k)%LANES))*LANE_W +: LANE_W];
        end

        always_comb begin
            lane_sel = '0;
            for (int unsigned k = 0; k < LANES; k++) begin
                if (rot_left_amt == AW'(k)) begin
                    lane_sel = cand_flat[k*LANE_W +: LANE_W];
                end
            end
        end

        assign rot_vec[(LANES-1-j)*LANE_W +: LANE_W] = lane_sel;
    end

    always_comb begin
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        step_d      = step_q;
        if (enable) begin
            if (accept) begin
                dout_d      = rot_vec;
                out_valid_d = 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (step_clr) begin
                step_d = '0;
            end else if (accept && auto_s) begin
                step_d = SEL_W'((step_sum >= LANES_A) ? (step_sum - LANES_A) : step_sum);
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            step_q      <= '0;
        end else begin
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            step_q      <= step_d;
        end
    end

    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign step_cnt  = step_q;

endmodule
